// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: the token alphabet, the
// answer_token_emitter state encoding and the double-dabble nibble adjust.
package calc_pkg;

  // Keypad-style token width; digits 0-9 map to tokens 4'h0-4'h9.
  localparam int TOKEN_W = 4;

  // Non-digit tokens shared with the keypad number builder.
  localparam logic [TOKEN_W-1:0] TOK_MINUS = 4'hB;
  localparam logic [TOKEN_W-1:0] TOK_EQUAL = 4'hE;

  // Emitter control states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SIZE    = 3'd2,
    ST_SIGN    = 3'd3,
    ST_EMIT    = 3'd4,
    ST_DONE    = 3'd5
  } emit_state_e;

  // Double-dabble correction: a BCD nibble of 5 or more gets 3 added before
  // the shift, so it carries cleanly into the next decimal digit. The result
  // never exceeds 4'hC, so no carry leaves the nibble.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/answer_token_emitter_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble core. load_i captures a binary value,
// clears the BCD register and arms a WIDTH-step counter; each step_i cycle
// performs one adjust-and-shift. finished_o is high once the counter is 0,
// and bcd_o then holds the decimal result until the next load or clear.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [WIDTH-1:0]        bin_i,
  input  logic                    step_i,
  output logic [4*MAX_DIGITS-1:0] bcd_o,
  output logic                    finished_o
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Apply the add-3 correction to every BCD nibble ahead of the shift.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so a
    // path that skips an assignment cannot infer a latch.
    bcd_adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dabble_adjust(bcd_q[4*i +: 4]);
    end
  end

  // Next-state for the shift register pair and the step counter.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (step_i && (cnt_q != '0)) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d          = cnt_q - CNT_W'(1);
    end
  end

  // Conversion registers; reset and clear both return the core to empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and the ordering of statements is irrelevant.
    // The wide shift registers are ordinary flops (not a memory), so they are
    // cleared by the synchronous reset like the rest of the state.
    if (!reset_n || clear_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o      = bcd_q;
  assign finished_o = (cnt_q == '0);

endmodule

// File: rtl/answer_token_emitter.sv
// answer_token_emitter: converts the calculator's binary answer to decimal
// with a sequential double-dabble, then streams the significant digits most
// significant first as keypad tokens over a valid/ready handshake.
// Optional feature macro: SIGNED_EN -- treat value as two's complement and
// emit TOK_MINUS ahead of the digits of a negative answer.
module answer_token_emitter
  import calc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  input  logic               clear,
  output logic               busy,
  output logic               token_valid,
  output logic [TOKEN_W-1:0] token,
  input  logic               token_ready,
  output logic [3:0]         digit_count,
  output logic               done
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int PTR_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  emit_state_e        state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               token_valid_q;
  logic [TOKEN_W-1:0] token_q;
  logic [3:0]         digit_count_q;
  logic               done_q;

  logic [WIDTH-1:0]   magnitude;
  logic               conv_load;
  logic               conv_step;
  logic               conv_finished;
  logic [BCD_W-1:0]   bcd;
  logic [3:0]         sig_digits;
  logic [PTR_W-1:0]   top_ptr;
  logic [3:0]         nib_top;
  logic [3:0]         nib_at_ptr;
  logic [3:0]         nib_below;
  logic               xfer;

`ifdef SIGNED_EN
  logic value_neg;
  logic sign_pending_q;

  // Negative answers are converted as their unsigned magnitude; the most
  // negative value wraps to itself, which reads correctly as unsigned.
  assign value_neg = value[WIDTH-1];
  assign magnitude = value_neg ? (WIDTH'(0) - value) : value;
`else
  assign magnitude = value;
`endif

  assign conv_load = (state_q == ST_IDLE) && start && !clear;
  assign conv_step = (state_q == ST_CONVERT);
  assign xfer      = token_valid_q && token_ready;

  bin2bcd_seq #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_bin2bcd (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear),
    .load_i     (conv_load),
    .bin_i      (magnitude),
    .step_i     (conv_step),
    .bcd_o      (bcd),
    .finished_o (conv_finished)
  );

  // Leading-zero sizing: position of the highest nonzero BCD digit, at least 1.
  always_comb begin
    sig_digits = 4'd1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        sig_digits = 4'(i + 1);
      end
    end
    top_ptr = PTR_W'(sig_digits - 4'd1);
  end

  // Digit selection for the top digit, the current pointer and the one below.
  always_comb begin
    nib_top    = 4'd0;
    nib_at_ptr = 4'd0;
    nib_below  = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (PTR_W'(i) == top_ptr) begin
        nib_top = bcd[4*i +: 4];
      end
      if (PTR_W'(i) == ptr_q) begin
        nib_at_ptr = bcd[4*i +: 4];
      end
      if (PTR_W'(i) == (ptr_q - PTR_W'(1))) begin
        nib_below = bcd[4*i +: 4];
      end
    end
  end

  // Control FSM with registered handshake, sizing and completion outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      token_valid_q <= 1'b0;
      token_q       <= '0;
      digit_count_q <= 4'd0;
      done_q        <= 1'b0;
`ifdef SIGNED_EN
      sign_pending_q <= 1'b0;
`endif
    end else if (clear) begin
      // Abort: same as reset but the last digit count stays readable.
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      token_valid_q <= 1'b0;
      token_q       <= '0;
      done_q        <= 1'b0;
`ifdef SIGNED_EN
      sign_pending_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_CONVERT;
`ifdef SIGNED_EN
            sign_pending_q <= value_neg;
`endif
          end
        end

        ST_CONVERT: begin
          if (conv_finished) begin
            state_q <= ST_SIZE;
          end
        end

        ST_SIZE: begin
          ptr_q         <= top_ptr;
          token_valid_q <= 1'b1;
`ifdef SIGNED_EN
          if (sign_pending_q) begin
            digit_count_q <= sig_digits + 4'd1;
            token_q       <= TOK_MINUS;
            state_q       <= ST_SIGN;
          end else begin
            digit_count_q <= sig_digits;
            token_q       <= TOKEN_W'(nib_top);
            state_q       <= ST_EMIT;
          end
`else
          digit_count_q <= sig_digits;
          token_q       <= TOKEN_W'(nib_top);
          state_q       <= ST_EMIT;
`endif
        end

`ifdef SIGNED_EN
        ST_SIGN: begin
          // Minus sign accepted: present the leading digit without a bubble.
          if (xfer) begin
            sign_pending_q <= 1'b0;
            token_q        <= TOKEN_W'(nib_at_ptr);
            state_q        <= ST_EMIT;
          end
        end
`endif

        ST_EMIT: begin
          if (xfer) begin
            if (ptr_q == '0) begin
              token_valid_q <= 1'b0;
              token_q       <= '0;
              done_q        <= 1'b1;
              state_q       <= ST_DONE;
            end else begin
              ptr_q   <= ptr_q - PTR_W'(1);
              token_q <= TOKEN_W'(nib_below);
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q       <= ST_IDLE;
          token_valid_q <= 1'b0;
          token_q       <= '0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign token_valid = token_valid_q;
  assign token       = token_q;
  assign digit_count = digit_count_q;
  assign done        = done_q;

endmodule
